// File: rtl/string_feeder_if.sv
// Frame-control, line-buffer read and driver handshake signals of the string feeder.
// master: the feeder itself. slave: the sequencer/RAM/driver side.
interface string_feeder_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                  frame_start;
    logic [7:0]            brightness;
    logic                  frame_busy;
    logic                  frame_done;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [23:0]           rd_data;
    logic                  string_ready;
    logic [23:0]           pixel_data;
    logic                  pixel_data_valid;
    logic                  h_blank;

    modport master (
        input  frame_start, brightness, rd_data, string_ready,
        output frame_busy, frame_done, rd_en, rd_addr,
               pixel_data, pixel_data_valid, h_blank
    );

    modport slave (
        output frame_start, brightness, rd_data, string_ready,
        input  frame_busy, frame_done, rd_en, rd_addr,
               pixel_data, pixel_data_valid, h_blank
    );
endinterface

// File: rtl/string_feeder.sv
// string_feeder: walks one string of pixels out of the line buffer, scales each
// channel by the frame brightness, reorders RGB->GRB and hands pixels to the
// WS2812B driver one at a time, then requests a single h_blank per frame.

// One 8-bit channel scaler: (c * (brightness+1)) >> 8, so 255 is identity.
module string_feeder_scale (
    input  logic [7:0] chan,
    input  logic [7:0] bright,
    output logic [7:0] scaled
);
    logic [16:0] prod;
    logic        unused_prod;

    assign prod        = {9'd0, chan} * ({9'd0, bright} + 17'd1);
    assign scaled      = prod[15:8];
    // bit 16 can never be set (255*256 < 2^16); low byte is the discarded fraction
    assign unused_prod = ^{prod[16], prod[7:0]};
endmodule

module string_feeder #(
    parameter int NUM_LEDS     = 300,
    parameter int ADDR_WIDTH   = 9,
    parameter int GUARD_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    string_feeder_if.master bus
);
    localparam int NUM_CH = 3;
    localparam int GW     = $clog2(GUARD_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, CAPTURE, WAIT_RDY, GUARD, BLANK_RDY, BLANK_GUARD, DONE_RDY
    } state_t;

    state_t                     state, state_nxt;
    logic [ADDR_WIDTH-1:0]      addr;
    logic [7:0]                 bright;
    logic [GW-1:0]              guard;
    logic [23:0]                pixel_q;
    logic                       pix_vld_q;
    logic                       blank_q;
    logic                       last_pix;
    logic                       done;
    // channel lanes indexed to match rd_data: [2]=R, [1]=G, [0]=B
    logic [NUM_CH-1:0][7:0]     scaled;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
            string_feeder_scale u_scale (
                .chan   (bus.rd_data[gi*8 +: 8]),
                .bright (bright),
                .scaled (scaled[gi])
            );
        end
    endgenerate

    assign last_pix = (addr == ADDR_WIDTH'(NUM_LEDS - 1));

    // Next-state logic and the state-decoded outputs.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE:        if (bus.frame_start) state_nxt = FETCH;
            FETCH:       state_nxt = CAPTURE;
            CAPTURE:     state_nxt = WAIT_RDY;
            WAIT_RDY:    if (bus.string_ready) state_nxt = GUARD;
            GUARD:       if (guard == '0) state_nxt = last_pix ? BLANK_RDY : FETCH;
            BLANK_RDY:   if (bus.string_ready) state_nxt = BLANK_GUARD;
            BLANK_GUARD: if (guard == '0) state_nxt = DONE_RDY;
            DONE_RDY: begin
                // ready back high means the blank has finished on the string
                if (bus.string_ready) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default:     state_nxt = IDLE;
        endcase
    end

    // State register plus the datapath registers each state owns.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            bright    <= '0;
            guard     <= '0;
            pixel_q   <= '0;
            pix_vld_q <= 1'b0;
            blank_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            pix_vld_q <= 1'b0;
            blank_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.frame_start) begin
                        bright <= bus.brightness;
                        addr   <= '0;
                    end
                end
                CAPTURE: pixel_q <= {scaled[1], scaled[2], scaled[0]};
                WAIT_RDY: begin
                    if (bus.string_ready) begin
                        pix_vld_q <= 1'b1;
                        guard     <= GW'(GUARD_CYCLES);
                    end
                end
                GUARD: begin
                    // the driver drops ready a cycle after a strobe; do not look at it until then
                    if (guard != '0)    guard <= guard - GW'(1);
                    else if (!last_pix) addr  <= addr + ADDR_WIDTH'(1);
                end
                BLANK_RDY: begin
                    if (bus.string_ready) begin
                        blank_q <= 1'b1;
                        guard   <= GW'(GUARD_CYCLES);
                    end
                end
                BLANK_GUARD: if (guard != '0) guard <= guard - GW'(1);
                default: ;
            endcase
        end
    end

    assign bus.rd_en            = (state == FETCH);
    assign bus.rd_addr          = (state == FETCH) ? addr : '0;
    assign bus.pixel_data       = pixel_q;
    assign bus.pixel_data_valid = pix_vld_q;
    assign bus.h_blank          = blank_q;
    assign bus.frame_done       = done;
    // busy drops in the very cycle done pulses
    assign bus.frame_busy       = (state != IDLE) && !done;
endmodule

// File: tb/tb_string_feeder.sv
// Directed bench for string_feeder: 4-pixel string, RAM and WS2812B driver models.
module tb_string_feeder;
    localparam int NL = 4;
    localparam int AW = 3;
    localparam int GC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    string_feeder_if #(.ADDR_WIDTH(AW)) bus ();

    string_feeder #(.NUM_LEDS(NL), .ADDR_WIDTH(AW), .GUARD_CYCLES(GC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vecs = 0;
    int errs = 0;

    // line buffer: data the cycle after rd_en
    logic [23:0] mem [8];
    always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

    // driver: ready drops the cycle after a strobe, for pace_bits / pace_blank cycles
    int  pace_bits  = 0;
    int  pace_blank = 0;
    int  busy_cnt   = 0;
    bit  hold       = 1'b0;
    always @(posedge clk) begin
        if (bus.pixel_data_valid)  busy_cnt <= pace_bits;
        else if (bus.h_blank)      busy_cnt <= pace_blank;
        else if (busy_cnt != 0)    busy_cnt <= busy_cnt - 1;
    end
    assign bus.string_ready = !hold && (busy_cnt == 0);

    // monitor, sampled on the falling edge
    int          cyc = 0;
    int          rd_cnt = 0, pix_cnt = 0, hb_cnt = 0, done_cnt = 0, hb_cyc = 0;
    logic        busy_at_done = 1'b0;
    logic [23:0] pix_val [128];
    int          pix_cyc [128];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.rd_en) rd_cnt++;
        if (bus.pixel_data_valid) begin
            pix_val[pix_cnt & 127] = bus.pixel_data;
            pix_cyc[pix_cnt & 127] = cyc;
            pix_cnt++;
        end
        if (bus.h_blank) begin hb_cnt++; hb_cyc = cyc; end
        if (bus.frame_done) begin done_cnt++; busy_at_done = bus.frame_busy; end
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    // returns in cycle k+1 where k is the edge that sampled frame_start
    task automatic start_frame(input logic [7:0] b);
        tick();
        bus.brightness  = b;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    task automatic wait_done(input int d0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            tick();
            if (done_cnt > d0) ok = 1'b1;
        end
    endtask

    task automatic wait_pix(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            tick();
            if (pix_cnt >= target) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        vecs++; if (bus.rd_en !== 1'b0 || bus.rd_addr !== 3'd0) begin errs++; $display("FAIL reset_rd: rd_en=%b rd_addr=%0d want 0/0", bus.rd_en, bus.rd_addr); end
        vecs++; if (bus.pixel_data !== 24'h0 || bus.pixel_data_valid !== 1'b0) begin errs++; $display("FAIL reset_pix: data=%h vld=%b want 0", bus.pixel_data, bus.pixel_data_valid); end
        vecs++; if ({bus.h_blank, bus.frame_busy, bus.frame_done} !== 3'b000) begin errs++; $display("FAIL reset_ctl: blank/busy/done=%b want 000", {bus.h_blank, bus.frame_busy, bus.frame_done}); end
        rst = 1'b0;
        tick(); tick();
        vecs++; if (bus.frame_busy !== 1'b0 || bus.rd_en !== 1'b0) begin errs++; $display("FAIL idle_after_reset: busy=%b rd_en=%b want 0", bus.frame_busy, bus.rd_en); end
    endtask

    task automatic test_identity();
        int pb, rb, hb, db;
        bit ok;
        logic [23:0] exp_px [4];
        exp_px[0] = 24'h221133; exp_px[1] = 24'h00FF00; exp_px[2] = 24'hFF0000; exp_px[3] = 24'h0000FF;
        mem[0] = 24'h112233; mem[1] = 24'hFF0000; mem[2] = 24'h00FF00; mem[3] = 24'h0000FF;
        pace_bits = 8; pace_blank = 20;
        pb = pix_cnt; rb = rd_cnt; hb = hb_cnt; db = done_cnt;
        start_frame(8'd255);
        wait_done(db, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL identity_done: timeout waiting frame_done"); end
        vecs++; if (pix_cnt - pb !== 4) begin errs++; $display("FAIL identity_count: %0d strobes want 4", pix_cnt - pb); end
        for (int i = 0; i < 4; i++) begin
            vecs++; if (pix_val[(pb + i) & 127] !== exp_px[i]) begin errs++; $display("FAIL identity_px%0d: got %h want %h", i, pix_val[(pb + i) & 127], exp_px[i]); end
        end
        vecs++; if (hb_cnt - hb !== 1 || done_cnt - db !== 1) begin errs++; $display("FAIL identity_blank_done: blanks=%0d dones=%0d want 1/1", hb_cnt - hb, done_cnt - db); end
        vecs++; if (hb_cyc <= pix_cyc[(pb + 3) & 127]) begin errs++; $display("FAIL identity_blank_order: blank cyc %0d last pix cyc %0d", hb_cyc, pix_cyc[(pb + 3) & 127]); end
        vecs++; if (rd_cnt - rb !== 4) begin errs++; $display("FAIL identity_reads: %0d reads want 4", rd_cnt - rb); end
    endtask

    task automatic test_latency();
        int db;
        bit ok;
        pace_bits = 0; pace_blank = 0;
        db = done_cnt;
        start_frame(8'd255);
        vecs++; if (bus.rd_en !== 1'b1 || bus.rd_addr !== 3'd0) begin errs++; $display("FAIL lat_k1_read: rd_en=%b rd_addr=%0d want 1/0", bus.rd_en, bus.rd_addr); end
        vecs++; if (bus.frame_busy !== 1'b1) begin errs++; $display("FAIL lat_k1_busy: busy=%b want 1", bus.frame_busy); end
        tick();
        vecs++; if (bus.pixel_data !== 24'h0000FF || bus.pixel_data_valid !== 1'b0) begin errs++; $display("FAIL lat_k2_hold: data=%h vld=%b want 0000ff/0", bus.pixel_data, bus.pixel_data_valid); end
        tick();
        vecs++; if (bus.pixel_data !== 24'h221133 || bus.pixel_data_valid !== 1'b0) begin errs++; $display("FAIL lat_k3_capture: data=%h vld=%b want 221133/0", bus.pixel_data, bus.pixel_data_valid); end
        tick();
        vecs++; if (bus.pixel_data_valid !== 1'b1) begin errs++; $display("FAIL lat_k4_strobe: vld=%b want 1", bus.pixel_data_valid); end
        wait_done(db, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL lat_done: timeout waiting frame_done"); end
    endtask

    task automatic test_scaling();
        int pb, db;
        bit ok;
        logic [23:0] exp_px [4];
        exp_px[0] = 24'h407F00; exp_px[1] = 24'h100818; exp_px[2] = 24'h000000; exp_px[3] = 24'h7F7F7F;
        mem[0] = 24'hFF8000; mem[1] = 24'h102030; mem[2] = 24'h000000; mem[3] = 24'hFFFFFF;
        pace_bits = 3; pace_blank = 5;
        pb = pix_cnt; db = done_cnt;
        start_frame(8'd127);
        wait_done(db, ok);
        vecs++; if (!ok || pix_cnt - pb !== 4) begin errs++; $display("FAIL scale127_frame: ok=%b strobes=%0d want 1/4", ok, pix_cnt - pb); end
        for (int i = 0; i < 4; i++) begin
            vecs++; if (pix_val[(pb + i) & 127] !== exp_px[i]) begin errs++; $display("FAIL scale127_px%0d: got %h want %h", i, pix_val[(pb + i) & 127], exp_px[i]); end
        end
        pb = pix_cnt; db = done_cnt;
        start_frame(8'd0);
        wait_done(db, ok);
        vecs++; if (!ok || pix_cnt - pb !== 4) begin errs++; $display("FAIL scale0_frame: ok=%b strobes=%0d want 1/4", ok, pix_cnt - pb); end
        for (int i = 0; i < 4; i++) begin
            vecs++; if (pix_val[(pb + i) & 127] !== 24'h000000) begin errs++; $display("FAIL scale0_px%0d: got %h want 000000", i, pix_val[(pb + i) & 127]); end
        end
    endtask

    task automatic test_spacing();
        int pb, db;
        bit ok;
        mem[0] = 24'h010203; mem[1] = 24'h040506; mem[2] = 24'h070809; mem[3] = 24'h0A0B0C;
        pace_bits = 0; pace_blank = 0;
        pb = pix_cnt; db = done_cnt;
        start_frame(8'd255);
        wait_done(db, ok);
        vecs++; if (!ok || pix_cnt - pb !== 4) begin errs++; $display("FAIL spacing_frame: ok=%b strobes=%0d want 1/4", ok, pix_cnt - pb); end
        for (int i = 1; i < 4; i++) begin
            vecs++; if (pix_cyc[(pb + i) & 127] - pix_cyc[(pb + i - 1) & 127] < GC + 4) begin errs++; $display("FAIL spacing_px%0d: gap %0d want >= %0d", i, pix_cyc[(pb + i) & 127] - pix_cyc[(pb + i - 1) & 127], GC + 4); end
        end
        vecs++; if (hb_cyc - pix_cyc[(pb + 3) & 127] < GC + 1) begin errs++; $display("FAIL spacing_blank: gap %0d want >= %0d", hb_cyc - pix_cyc[(pb + 3) & 127], GC + 1); end
    endtask

    task automatic test_backpressure();
        int pb, rb, db, rel;
        bit ok;
        pace_bits = 8; pace_blank = 10;
        pb = pix_cnt; rb = rd_cnt; db = done_cnt;
        start_frame(8'd255);
        wait_pix(pb + 1, ok);
        hold = 1'b1;
        vecs++; if (!ok) begin errs++; $display("FAIL bp_first: timeout waiting first strobe"); end
        for (int i = 0; i < 100; i++) tick();
        vecs++; if (pix_cnt - pb !== 1) begin errs++; $display("FAIL bp_stall_strobes: %0d strobes want 1", pix_cnt - pb); end
        vecs++; if (rd_cnt - rb !== 2) begin errs++; $display("FAIL bp_stall_reads: %0d reads want 2", rd_cnt - rb); end
        hold = 1'b0;
        rel = cyc;
        wait_pix(pb + 2, ok);
        vecs++; if (!ok || pix_cyc[(pb + 1) & 127] - rel > 2) begin errs++; $display("FAIL bp_release: ok=%b delay %0d want <= 2", ok, pix_cyc[(pb + 1) & 127] - rel); end
        wait_done(db, ok);
        vecs++; if (!ok || pix_cnt - pb !== 4) begin errs++; $display("FAIL bp_frame: ok=%b strobes=%0d want 1/4", ok, pix_cnt - pb); end
    endtask

    task automatic test_ignored_start();
        int pb, rb, db;
        bit ok, hit;
        mem[0] = 24'h112233; mem[1] = 24'hFF0000; mem[2] = 24'h00FF00; mem[3] = 24'h0000FF;
        pace_bits = 6; pace_blank = 12;
        pb = pix_cnt; rb = rd_cnt; db = done_cnt;
        start_frame(8'd255);
        wait_pix(pb + 2, ok);
        // mid-frame request with a different brightness must not disturb anything
        bus.brightness  = 8'd0;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            tick();
            if (bus.frame_done === 1'b1) begin
                hit = 1'b1;
                bus.frame_start = 1'b1;
                tick();
                bus.frame_start = 1'b0;
            end
        end
        vecs++; if (!hit) begin errs++; $display("FAIL ign_done: timeout waiting frame_done"); end
        for (int i = 0; i < 30; i++) tick();
        vecs++; if (rd_cnt - rb !== 4) begin errs++; $display("FAIL ign_reads: %0d reads want 4", rd_cnt - rb); end
        vecs++; if (done_cnt - db !== 1 || pix_cnt - pb !== 4) begin errs++; $display("FAIL ign_counts: dones=%0d strobes=%0d want 1/4", done_cnt - db, pix_cnt - pb); end
        vecs++; if (busy_at_done !== 1'b0 || bus.frame_busy !== 1'b0) begin errs++; $display("FAIL ign_busy: busy at done=%b now=%b want 0/0", busy_at_done, bus.frame_busy); end
        vecs++; if (pix_val[(pb + 3) & 127] !== 24'h0000FF) begin errs++; $display("FAIL ign_bright: px3 %h want 0000ff", pix_val[(pb + 3) & 127]); end
    endtask

    task automatic test_reset_midframe();
        int pb, hb, db;
        bit ok;
        pace_bits = 8; pace_blank = 10;
        pb = pix_cnt; hb = hb_cnt; db = done_cnt;
        start_frame(8'd255);
        wait_pix(pb + 2, ok);
        vecs++; if (!ok || bus.pixel_data !== 24'h00FF00) begin errs++; $display("FAIL rstmid_pre: ok=%b data=%h want 1/00ff00", ok, bus.pixel_data); end
        rst = 1'b1;
        tick();
        vecs++; if ({bus.rd_en, bus.rd_addr, bus.pixel_data, bus.pixel_data_valid, bus.h_blank, bus.frame_busy, bus.frame_done} !== '0) begin
            errs++; $display("FAIL rstmid_outputs: rd_en=%b addr=%0d data=%h vld=%b blank=%b busy=%b done=%b want all 0",
                bus.rd_en, bus.rd_addr, bus.pixel_data, bus.pixel_data_valid, bus.h_blank, bus.frame_busy, bus.frame_done);
        end
        rst = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        vecs++; if (hb_cnt - hb !== 0 || done_cnt - db !== 0) begin errs++; $display("FAIL rstmid_noblank: blanks=%0d dones=%0d want 0/0", hb_cnt - hb, done_cnt - db); end
        pb = pix_cnt; db = done_cnt;
        start_frame(8'd255);
        vecs++; if (bus.rd_en !== 1'b1 || bus.rd_addr !== 3'd0) begin errs++; $display("FAIL rstmid_restart: rd_en=%b rd_addr=%0d want 1/0", bus.rd_en, bus.rd_addr); end
        wait_done(db, ok);
        vecs++; if (!ok || pix_cnt - pb !== 4 || pix_val[pb & 127] !== 24'h221133) begin errs++; $display("FAIL rstmid_frame: ok=%b strobes=%0d px0=%h want 1/4/221133", ok, pix_cnt - pb, pix_val[pb & 127]); end
    endtask

    initial begin
        bus.frame_start = 1'b0;
        bus.brightness  = 8'd0;
        for (int i = 0; i < 8; i++) mem[i] = 24'h0;
        test_reset();
        test_identity();
        test_latency();
        test_scaling();
        test_spacing();
        test_backpressure();
        test_ignored_start();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
